// File: rtl/pipe_cla_addsub.sv
// Pipelined add/subtract unit: each stage resolves one contiguous slice of
// the result with 4-bit carry-lookahead groups, LSB slice first.
module pipe_cla_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SLICE  = WIDTH / STAGES;
  localparam int GROUPS = SLICE / 4;
  localparam int LAST   = STAGES - 1;

  if ((WIDTH % 4) != 0 || STAGES < 1 || STAGES > WIDTH / 4 || ((WIDTH / 4) % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_cla_addsub: unsupported WIDTH/STAGES combination");
  end

  logic en;

  // One 4-bit lookahead group: every internal carry is a flat sum of
  // products, so nothing ripples bit to bit. Returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [3:0] g, p;
    logic       c1, c2, c3, gg, pg;
    g  = x & y;
    p  = x ^ y;
    c1 = g[0] | (p[0] & c);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pg = &p;
    return {gg | (pg & c), p ^ {c3, c2, c1, c}};
  endfunction

  // Whole pipeline moves together; a held result freezes every stage.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // bx_in carries only the not-yet-consumed part of the effective B.
    localparam int BW = WIDTH - k * SLICE;

    logic             v_in, c_in;
    logic [WIDTH-1:0] d_in;
    logic [BW-1:0]    bx_in;
    logic             c_nx;
    logic [WIDTH-1:0] d_nx;
    logic             v_q, c_q;
    logic [WIDTH-1:0] d_q;

    if (k == 0) begin : g_first
      assign v_in  = in_valid;
      assign c_in  = sub ^ cin;
      assign d_in  = a;
      assign bx_in = sub ? ~b : b;
    end else begin : g_next
      assign v_in  = g_stage[k-1].v_q;
      assign c_in  = g_stage[k-1].c_q;
      assign d_in  = g_stage[k-1].d_q;
      assign bx_in = g_stage[k-1].g_pass.bx_q;
    end

    // d holds finished sum bits below this slice and raw A bits above it.
    // NOTE: always_comb assigns every output a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
      c_nx = c_in;
      d_nx = d_in;
      for (int j = 0; j < GROUPS; j++) begin
        {c_nx, d_nx[k*SLICE + 4*j +: 4]} = cla4(d_in[k*SLICE + 4*j +: 4], bx_in[4*j +: 4], c_nx);
      end
    end

    // NOTE: state registers use non-blocking assignments so all stages sample pre-edge values simultaneously.
    // NOTE: datapath registers are reset too, because reset must show sum/cout/ovf/zero as 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        d_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        c_q <= c_nx;
        d_q <= d_nx;
      end
    end

    if (k == LAST) begin : g_last
      logic ovf_q, zero_q;
      // The top slice of d_in is still raw A here, so its MSB is a[MSB].
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (en) begin
          ovf_q  <= (d_in[WIDTH-1] == bx_in[BW-1]) && (d_nx[WIDTH-1] != d_in[WIDTH-1]);
          zero_q <= (d_nx == '0);
        end
      end
    end else begin : g_pass
      logic [BW-SLICE-1:0] bx_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bx_q <= '0;
        end else if (en) begin
          bx_q <= bx_in[BW-1:SLICE];
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].v_q;
  assign sum       = g_stage[LAST].d_q;
  assign cout      = g_stage[LAST].c_q;
  assign ovf       = g_stage[LAST].g_last.ovf_q;
  assign zero      = g_stage[LAST].g_last.zero_q;

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Scoreboard bench for pipe_cla_addsub (WIDTH=16, STAGES=2): directed corner
// cases, backpressure, mid-stream reset and a randomized valid/ready soak.
module tb_pipe_cla_addsub;
  localparam int W  = 16;
  localparam int ST = 2;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cout, ovf, zero;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout, ovf, zero;
    bit           lat;
    int           acc_edge;
  } exp_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic         ci, s;
    logic [W-1:0] es;
    logic         ec, eo, ez;
  } vec_t;

  exp_t sbq[$];
  int   n_checks   = 0;
  int   n_err      = 0;
  int   cyc        = 0;
  int   stall_left = 0;
  bit   rnd_ready  = 1'b0;
  bit   lat_mode   = 1'b0;

  pipe_cla_addsub #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic; overflow means the signed result
  // does not fit in W bits.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
    exp_t         m;
    logic [W-1:0] be;
    int unsigned  u;
    int           r, bi;
    be = s ? ~y : y;
    bi = (s ? !ci : ci) ? 1 : 0;
    u  = 32'(x) + 32'(be) + bi;
    r  = int'($signed(x)) + int'($signed(be)) + bi;
    m.sum      = u[W-1:0];
    m.cout     = u[W];
    m.ovf      = (r > 32767) || (r < -32768);
    m.zero     = (u[W-1:0] == '0);
    m.lat      = 1'b0;
    m.acc_edge = 0;
    return m;
  endfunction

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s, input exp_t e);
    bit done;
    done = 1'b0;
    @(negedge clk);
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      #1;
      if (in_ready) begin
        e.acc_edge = cyc + 1;
        e.lat      = lat_mode;
        sbq.push_back(e);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_rnd();
    logic [W-1:0] x, y;
    logic         ci, s;
    logic [W-1:0] corner [4];
    corner = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    x  = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : W'($urandom);
    y  = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : W'($urandom);
    ci = 1'($urandom);
    s  = 1'($urandom);
    issue(x, y, ci, s, model(x, y, ci, s));
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sbq.size() > 0; t++) @(negedge clk);
    check("drain_empty", sbq.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Downstream ready driver: forced stalls take priority over random mode.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rnd_ready) begin
        out_ready = ($urandom_range(3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: samples mid-low-phase, pops the scoreboard on each transfer.
  initial begin
    exp_t         e;
    logic [W-1:0] h_sum;
    logic [2:0]   h_flags;
    bit           held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        check("in_ready_rule", in_ready, !out_valid || out_ready);
        if (held) begin
          check("hold_valid", out_valid, 1);
          check("hold_sum", sum, h_sum);
          check("hold_flags", {cout, ovf, zero}, h_flags);
        end
        held    = out_valid && !out_ready;
        h_sum   = sum;
        h_flags = {cout, ovf, zero};
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            e = sbq.pop_front();
            check("sum", sum, e.sum);
            check("cout", cout, e.cout);
            check("ovf", ovf, e.ovf);
            check("zero", zero, e.zero);
            if (e.lat) check("latency", cyc - e.acc_edge, ST - 1);
          end
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    vec_t dir [8];
    exp_t e;
    dir = '{
      '{16'h0006, 16'hFFFD, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0},
      '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0},
      '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1},
      '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0},
      '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0},
      '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
      '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0},
      '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0}
    };
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_flags", {cout, ovf, zero}, 0);
    check("rst_in_ready", in_ready, 1);
    #10 rst_n = 1'b1;

    // Directed corner cases with hand-derived expectations, latency checked.
    lat_mode = 1'b1;
    foreach (dir[i]) begin
      e = '{sum: dir[i].es, cout: dir[i].ec, ovf: dir[i].eo, zero: dir[i].ez, lat: 1'b0, acc_edge: 0};
      issue(dir[i].a, dir[i].b, dir[i].ci, dir[i].s, e);
    end
    drain();

    // Backpressure: a 3-cycle stall lands while the fourth op is pending.
    lat_mode = 1'b0;
    for (int i = 0; i < 3; i++) send_rnd();
    stall_left = 3;
    send_rnd();
    drain();

    // Mid-stream reset: two ops in flight are discarded.
    lat_mode = 1'b1;
    send_rnd();
    send_rnd();
    #1 check("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_in_ready", in_ready, 1);
    sbq.delete();
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_rnd();
    drain();

    // Random soak with random downstream readiness and input bubbles.
    lat_mode  = 1'b0;
    rnd_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      send_rnd();
      if ($urandom_range(3) == 0) @(negedge clk);
    end
    rnd_ready = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
